sv_lockstep_compare: RTL and testbench
======================================

// Module: sv_lockstep_compare
// PURPOSE
//  Synthesizable lockstep equivalence checker for stereovision2: compares NUM_CH output channels of a candidate
//  design (act) against the golden design (exp) at a fixed sample interval after a reset-settle window.
//  Drives the stimulus-update strobe, counts mismatches and captures the first failure.
//  Sits beside sv_chip2_hierarchy_no_mem / _src pairs in FPGA or emulation regression; replaces the behavioural
//  #5000 / #500 checking loop.
// PARAMETERS
//  NUM_CH         16       number of compared channels
//  CH_W           64       bits per channel; narrower outputs are zero-padded by the integrator
//  SETTLE_CYCLES  250      cycles between start and first stimulus (5000 ns @ 20 ns clk); 0 = none
//  SAMPLE_PERIOD  25       cycles per sample (500 ns); legal range >= 2
//  NUM_SAMPLES    1000000  compares per run; legal range >= 1
// PORTS
//  tm3_clk_v0      in   1            sole clock, rising edge
//  reset           in   1            asynchronous, active-low (0 = reset)
//  start           in   1            1-cycle pulse; begins a run from IDLE/DONE/FAIL
//  abort           in   1            forces IDLE; wins over start
//  ch_mask         in   NUM_CH       1 = channel compared; sampled at the compare cycle
//  act_bus         in   NUM_CH*CH_W  candidate outputs; channel k = [k*CH_W +: CH_W]
//  exp_bus         in   NUM_CH*CH_W  golden outputs, same packing
//  stim_stb        out  1            1-cycle: testbench/LFSR applies new stimulus
//  busy            out  1            state is SETTLE or RUN
//  done            out  1            sticky until next start/abort: run finished
//  pass            out  1            done && mismatch_cnt==0
//  fail            out  1            sticky: at least one mismatch in this run
//  sample_idx      out  32           compares completed this run
//  mismatch_cnt    out  32           mismatching samples, saturates at 2^32-1
//  first_fail_idx  out  32           sample_idx of first mismatch
//  first_fail_ch   out  clog2(NUM_CH) lowest mismatching channel of first failing sample
//  first_fail_act  out  CH_W         act value of that channel
//  first_fail_exp  out  CH_W         exp value of that channel
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE.
//  FSM: IDLE -start-> SETTLE (SETTLE_CYCLES==0 -> RUN directly); SETTLE -count done-> RUN;
//   RUN -NUM_SAMPLES compares-> DONE; abort in any state -> IDLE with all counters and stickies cleared.
//  start in SETTLE/RUN ignored. start in DONE/FAIL clears all counters, stickies and captures, then enters SETTLE.
//  RUN period counter p = 0..SAMPLE_PERIOD-1. stim_stb=1 when p==0.
//   At p==SAMPLE_PERIOD-1 compare vector mm[k] = ch_mask[k] && act_k!=exp_k is registered.
//  Evaluation one cycle later (latency 1): sample_idx+1.
//   If |mm: mismatch_cnt+1 (saturating) and fail=1.
//   If first failure: capture idx, lowest k, act, exp; captures are never overwritten within a run.
//  Evaluation overlaps p==0 of the next period, so stim_stb and an evaluation may coincide; both happen.
//  DONE entered on the cycle the NUM_SAMPLES-th evaluation completes; no stim_stb issued after the last compare.
//  X/Z on act/exp counts as mismatch in simulation (!== semantics in the bench model only).
// CONFIGURATION
//  SV_CMP_STOP_ON_FAIL_EN defined: the first mismatch moves RUN -> FAIL (done=1, pass=0) and halts,
//   mirroring $stop; sample_idx freezes at the failing index.
//  Undefined: run continues to NUM_SAMPLES, accumulating mismatch_cnt; FAIL state unused.
// STRUCTURE
//  Package sv_cmp_pkg: state enum {IDLE,SETTLE,RUN,DONE,FAIL}; CNT_W=32; function clog2.
//  Sub-module sv_cmp_chan_sel: NUM_CH-way priority encoder on mm plus act/exp mux of the selected channel;
//   purely combinational, instantiated once.
// TESTING
//  1) NUM_CH=4,CH_W=8,SETTLE=10,PERIOD=5,SAMPLES=8, act==exp: start -> first stim_stb at cycle 11;
//     done at 8th eval; pass=1, mismatch_cnt=0.
//  2) Same, act ch2 != exp only at sample 3 -> mismatch_cnt=1, first_fail_idx=3, first_fail_ch=2,
//     captured act/exp match injected values.
//  3) Mismatch on ch1 and ch3 same sample, ch_mask=4'b1101 -> first_fail_ch=3; ch_mask=0 -> pass=1.
//  4) SV_CMP_STOP_ON_FAIL_EN defined, mismatch at sample 2 -> FAIL, done=1, sample_idx=3 frozen, no further stim_stb.
//  5) abort mid-RUN, then start -> counters 0, first capture re-armed, full run repeats identically.
//  6) reset asserted low mid-RUN -> all outputs 0 asynchronously; SETTLE_CYCLES=0 -> stim_stb on cycle after start.

Source files
------------

// File: rtl/sv_cmp_pkg.sv
// Shared types and helpers for the lockstep compare block: run-state encoding, counter width, index sizing.
package sv_cmp_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } sv_cmp_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single channel still needs a 1-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sv_cmp_chan_sel.sv
// Combinational selector: picks the lowest set bit of the mismatch vector and muxes out that channel's act/exp.
module sv_cmp_chan_sel
  import sv_cmp_pkg::*;
#(
  parameter int  NUM_CH   = 16,
  parameter int  CH_W     = 64,
  localparam int CH_IDX_W = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0]      mm,
  input  logic [NUM_CH*CH_W-1:0] act_bus,
  input  logic [NUM_CH*CH_W-1:0] exp_bus,
  output logic [CH_IDX_W-1:0]    sel_ch,
  output logic [CH_W-1:0]        sel_act,
  output logic [CH_W-1:0]        sel_exp
);

  // Walking from the top down leaves the lowest mismatching channel as the final assignment.
  always_comb begin
    sel_ch  = '0;
    sel_act = '0;
    sel_exp = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mm[k]) begin
        sel_ch  = CH_IDX_W'(k);
        sel_act = act_bus[k*CH_W +: CH_W];
        sel_exp = exp_bus[k*CH_W +: CH_W];
      end
    end
  end

endmodule

// File: rtl/sv_lockstep_compare.sv
// Lockstep equivalence checker: settles, strobes stimulus, samples NUM_CH channels once per period and tracks
// mismatches. Define SV_CMP_STOP_ON_FAIL_EN to halt in FAIL on the first mismatching sample.
module sv_lockstep_compare
  import sv_cmp_pkg::*;
#(
  parameter int  NUM_CH        = 16,
  parameter int  CH_W          = 64,
  parameter int  SETTLE_CYCLES = 250,
  parameter int  SAMPLE_PERIOD = 25,
  parameter int  NUM_SAMPLES   = 1000000,
  localparam int CH_IDX_W      = ch_idx_w(NUM_CH)
) (
  input  logic                   tm3_clk_v0,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic [NUM_CH*CH_W-1:0] act_bus,
  input  logic [NUM_CH*CH_W-1:0] exp_bus,
  output logic                   stim_stb,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [CNT_W-1:0]       sample_idx,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       first_fail_idx,
  output logic [CH_IDX_W-1:0]    first_fail_ch,
  output logic [CH_W-1:0]        first_fail_act,
  output logic [CH_W-1:0]        first_fail_exp,
  output sv_cmp_state_e          dbg_state
);

  // Handshake: start/abort are 1-cycle request pulses (abort wins); stim_stb is a 1-cycle strobe with no
  // backpressure -- the environment must apply new stimulus before the compare at the end of the period.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(NUM_SAMPLES - 1);

  sv_cmp_state_e state_q, state_d;
  logic [CNT_W-1:0]    settle_q, settle_d, per_q, per_d, cmp_q, cmp_d;
  logic                last_q, last_d, eval_q, eval_d, mm_any_q, mm_any_d;
  logic [CH_IDX_W-1:0] mm_ch_q, mm_ch_d, ff_ch_q, ff_ch_d;
  logic [CH_W-1:0]     mm_act_q, mm_act_d, mm_exp_q, mm_exp_d;
  logic [CH_W-1:0]     ff_act_q, ff_act_d, ff_exp_q, ff_exp_d;
  logic [CNT_W-1:0]    sample_idx_q, sample_idx_d, mismatch_q, mismatch_d, ff_idx_q, ff_idx_d;
  logic                fail_q, fail_d;
  logic [NUM_CH-1:0]   mm_cmp;
  logic [CH_IDX_W-1:0] sel_ch;
  logic [CH_W-1:0]     sel_act, sel_exp;
  logic                clr;

  always_comb begin
    mm_cmp = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mm_cmp[k] = ch_mask[k] && (act_bus[k*CH_W +: CH_W] != exp_bus[k*CH_W +: CH_W]);
    end
  end

  sv_cmp_chan_sel #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_chan_sel (
    .mm      (mm_cmp),
    .act_bus (act_bus),
    .exp_bus (exp_bus),
    .sel_ch  (sel_ch),
    .sel_act (sel_act),
    .sel_exp (sel_exp)
  );

  assign clr = abort || (start && (state_q inside {ST_IDLE, ST_DONE, ST_FAIL}));

  always_ff @(posedge tm3_clk_v0 or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: if (start) state_d = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
        ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_RUN;
        ST_RUN: begin
          if (eval_q && last_q) state_d = ST_DONE;
`ifdef SV_CMP_STOP_ON_FAIL_EN
          if (eval_q && mm_any_q) state_d = ST_FAIL;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stim_stb = (state_q == ST_RUN) && (per_q == '0) && !last_q;
    busy     = state_q inside {ST_SETTLE, ST_RUN};
    done     = state_q inside {ST_DONE, ST_FAIL};
    pass     = (state_q == ST_DONE) && (mismatch_q == '0);
  end

  // Compare registers the mismatch vector and selected channel; evaluation commits it one cycle later.
  always_comb begin
    settle_d = settle_q;  per_d = per_q;  cmp_d = cmp_q;  last_d = last_q;
    eval_d   = 1'b0;      mm_any_d = mm_any_q;  mm_ch_d = mm_ch_q;
    mm_act_d = mm_act_q;  mm_exp_d = mm_exp_q;
    sample_idx_d = sample_idx_q;  mismatch_d = mismatch_q;  fail_d = fail_q;
    ff_idx_d = ff_idx_q;  ff_ch_d = ff_ch_q;  ff_act_d = ff_act_q;  ff_exp_d = ff_exp_q;
    if (clr) begin
      settle_d = '0;  per_d = '0;  cmp_d = '0;  last_d = 1'b0;  mm_any_d = 1'b0;
      mm_ch_d = '0;  mm_act_d = '0;  mm_exp_d = '0;
      sample_idx_d = '0;  mismatch_d = '0;  fail_d = 1'b0;
      ff_idx_d = '0;  ff_ch_d = '0;  ff_act_d = '0;  ff_exp_d = '0;
    end else if (state_q == ST_SETTLE) begin
      settle_d = settle_q + CNT_W'(1);
    end else if (state_q == ST_RUN) begin
      per_d = (per_q == PER_LAST) ? '0 : per_q + CNT_W'(1);
      if ((per_q == PER_LAST) && !last_q) begin
        eval_d   = 1'b1;
        mm_any_d = |mm_cmp;
        mm_ch_d  = sel_ch;
        mm_act_d = sel_act;
        mm_exp_d = sel_exp;
        cmp_d    = cmp_q + CNT_W'(1);
        last_d   = (cmp_q == SAMP_LAST);
      end
      if (eval_q) begin
        sample_idx_d = sample_idx_q + CNT_W'(1);
        if (mm_any_q) begin
          if (mismatch_q != '1) mismatch_d = mismatch_q + CNT_W'(1);
          fail_d = 1'b1;
          if (!fail_q) begin
            ff_idx_d = sample_idx_q;
            ff_ch_d  = mm_ch_q;
            ff_act_d = mm_act_q;
            ff_exp_d = mm_exp_q;
          end
        end
      end
    end
  end

  always_ff @(posedge tm3_clk_v0 or negedge reset) begin
    if (!reset) begin
      settle_q <= '0;  per_q <= '0;  cmp_q <= '0;  last_q <= 1'b0;  eval_q <= 1'b0;
      mm_any_q <= 1'b0;  mm_ch_q <= '0;  mm_act_q <= '0;  mm_exp_q <= '0;
      sample_idx_q <= '0;  mismatch_q <= '0;  fail_q <= 1'b0;
      ff_idx_q <= '0;  ff_ch_q <= '0;  ff_act_q <= '0;  ff_exp_q <= '0;
    end else begin
      settle_q <= settle_d;  per_q <= per_d;  cmp_q <= cmp_d;  last_q <= last_d;  eval_q <= eval_d;
      mm_any_q <= mm_any_d;  mm_ch_q <= mm_ch_d;  mm_act_q <= mm_act_d;  mm_exp_q <= mm_exp_d;
      sample_idx_q <= sample_idx_d;  mismatch_q <= mismatch_d;  fail_q <= fail_d;
      ff_idx_q <= ff_idx_d;  ff_ch_q <= ff_ch_d;  ff_act_q <= ff_act_d;  ff_exp_q <= ff_exp_d;
    end
  end

  assign fail           = fail_q;
  assign sample_idx     = sample_idx_q;
  assign mismatch_cnt   = mismatch_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_ch  = ff_ch_q;
  assign first_fail_act = ff_act_q;
  assign first_fail_exp = ff_exp_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sv_lockstep_compare.sv
// Directed bench for sv_lockstep_compare (4 ch x 8 bit); honours SV_CMP_STOP_ON_FAIL_EN when defined.
module tb_sv_lockstep_compare;

`ifdef SV_CMP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, start_z = 1'b0, abort_z = 1'b0;
  logic [3:0]  ch_mask = 4'hF;
  logic [31:0] act_bus = '0, exp_bus = '0;

  logic        stim_stb, busy, done, pass, fail;
  logic [31:0] sample_idx, mismatch_cnt, first_fail_idx;
  logic [1:0]  first_fail_ch;
  logic [7:0]  first_fail_act, first_fail_exp;
  logic [2:0]  dbg_state;

  logic        stim_stb_z, busy_z, done_z, pass_z, fail_z;
  logic [31:0] sample_idx_z, mismatch_cnt_z, first_fail_idx_z;
  logic [1:0]  first_fail_ch_z;
  logic [7:0]  first_fail_act_z, first_fail_exp_z;
  logic [2:0]  dbg_state_z;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  sv_lockstep_compare #(.NUM_CH(4), .CH_W(8), .SETTLE_CYCLES(10), .SAMPLE_PERIOD(5), .NUM_SAMPLES(8)) dut (
    .tm3_clk_v0(clk), .reset(rst_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .act_bus(act_bus), .exp_bus(exp_bus), .stim_stb(stim_stb), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .sample_idx(sample_idx), .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_ch(first_fail_ch), .first_fail_act(first_fail_act), .first_fail_exp(first_fail_exp),
    .dbg_state(dbg_state)
  );

  sv_lockstep_compare #(.NUM_CH(4), .CH_W(8), .SETTLE_CYCLES(0), .SAMPLE_PERIOD(2), .NUM_SAMPLES(2)) dut_z (
    .tm3_clk_v0(clk), .reset(rst_n), .start(start_z), .abort(abort_z), .ch_mask(ch_mask),
    .act_bus(act_bus), .exp_bus(exp_bus), .stim_stb(stim_stb_z), .busy(busy_z), .done(done_z),
    .pass(pass_z), .fail(fail_z), .sample_idx(sample_idx_z), .mismatch_cnt(mismatch_cnt_z),
    .first_fail_idx(first_fail_idx_z), .first_fail_ch(first_fail_ch_z),
    .first_fail_act(first_fail_act_z), .first_fail_exp(first_fail_exp_z), .dbg_state(dbg_state_z)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Sample s, channel k carries s*16+k+1; listed bad channels of sample bad_s get act = exp ^ 8'hA5.
  task automatic drive_sample(input int s, input int bad_s, input logic [3:0] bad_chans);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'(s * 16 + k + 1);
      exp_bus[k*8 +: 8] = e;
      act_bus[k*8 +: 8] = ((s == bad_s) && bad_chans[k]) ? (e ^ 8'hA5) : e;
    end
  endtask

  // Pulses start, then services stim_stb each cycle. Cycle 1 is the first cycle after start is sampled.
  // Stops on done, at stop_at (abort, or reset if by_reset), or at the cycle budget.
  task automatic do_run(input int bad_s, input logic [3:0] bad_chans, input int stop_at, input bit by_reset,
                        output int stb_n, output int first_stb, output int done_cyc);
    int cyc;
    bit fin;
    stb_n = 0; first_stb = -1; done_cyc = -1; fin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin) begin
      if (stim_stb) begin
        if (first_stb < 0) first_stb = cyc;
        drive_sample(stb_n, bad_s, bad_chans);
        stb_n++;
      end
      if (cyc == stop_at) begin
        if (by_reset) begin
          #3 rst_n = 1'b0;
          #1;
        end else begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
        end
        fin = 1'b1;
      end else if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (cyc >= 400) begin
        check("run_timeout", {63'd0, done}, 64'd1);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic count_stb(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (stim_stb) c++;
    end
  endtask

  initial begin
    int n, f, d, c, cyc;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_stim_stb", stim_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_sample_idx", sample_idx, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) clean run
    ch_mask = 4'hF;
    do_run(-1, 4'b0000, -1, 1'b0, n, f, d);
    check("t1_first_stb", f, 11);
    check("t1_stb_n", n, 8);
    check("t1_done_cyc", d, 52);
    check("t1_pass", pass, 1);
    check("t1_mismatch", mismatch_cnt, 0);
    check("t1_sample_idx", sample_idx, 8);
    check("t1_state", dbg_state, 3);
    count_stb(10, c);
    check("t1_no_stb_after", c, 0);

    // 2) ch2 wrong at sample 3
    do_run(3, 4'b0100, -1, 1'b0, n, f, d);
    check("t2_mismatch", mismatch_cnt, 1);
    check("t2_ff_idx", first_fail_idx, 3);
    check("t2_ff_ch", first_fail_ch, 2);
    check("t2_ff_act", first_fail_act, 8'h96);
    check("t2_ff_exp", first_fail_exp, 8'h33);
    check("t2_fail", fail, 1);
    check("t2_pass", pass, 0);
    check("t2_done", done, 1);
    check("t2_sample_idx", sample_idx, STOP ? 4 : 8);
    check("t2_stb_n", n, STOP ? 5 : 8);
    check("t2_done_cyc", d, STOP ? 32 : 52);

    // 3) ch1 and ch3 wrong, ch1 masked; then everything masked
    ch_mask = 4'b1101;
    do_run(3, 4'b1010, -1, 1'b0, n, f, d);
    check("t3_ff_ch", first_fail_ch, 3);
    check("t3_ff_act", first_fail_act, 8'h91);
    check("t3_ff_exp", first_fail_exp, 8'h34);
    check("t3_mismatch", mismatch_cnt, 1);
    ch_mask = 4'b0000;
    do_run(3, 4'b1010, -1, 1'b0, n, f, d);
    check("t3_mask0_pass", pass, 1);
    check("t3_mask0_fail", fail, 0);
    check("t3_mask0_mismatch", mismatch_cnt, 0);
    check("t3_mask0_ff_ch", first_fail_ch, 0);

    // 4) ch2 wrong at sample 2: halts in FAIL when stop-on-fail is built in
    ch_mask = 4'hF;
    do_run(2, 4'b0100, -1, 1'b0, n, f, d);
    check("t4_done", done, 1);
    check("t4_pass", pass, 0);
    check("t4_sample_idx", sample_idx, STOP ? 3 : 8);
    check("t4_state", dbg_state, STOP ? 4 : 3);
    check("t4_done_cyc", d, STOP ? 27 : 52);
    check("t4_ff_idx", first_fail_idx, 2);
    check("t4_ff_act", first_fail_act, 8'h86);
    count_stb(20, c);
    check("t4_no_stb_after", c, 0);
    check("t4_idx_frozen", sample_idx, STOP ? 3 : 8);

    // 5) abort after the first failure is captured, then an identical full run
    do_run(4, 4'b0001, 37, 1'b0, n, f, d);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_state", dbg_state, 0);
    check("t5_abort_idx", sample_idx, 0);
    check("t5_abort_mismatch", mismatch_cnt, 0);
    check("t5_abort_fail", fail, 0);
    check("t5_abort_ff_act", first_fail_act, 0);
    do_run(4, 4'b0001, -1, 1'b0, n, f, d);
    check("t5_first_stb", f, 11);
    check("t5_done_cyc", d, STOP ? 37 : 52);
    check("t5_ff_idx", first_fail_idx, 4);
    check("t5_ff_ch", first_fail_ch, 0);
    check("t5_ff_act", first_fail_act, 8'hE4);
    check("t5_ff_exp", first_fail_exp, 8'h41);
    check("t5_mismatch", mismatch_cnt, 1);

    // 6) asynchronous reset mid-run, sampled between clock edges
    do_run(3, 4'b0001, 32, 1'b1, n, f, d);
    check("t6_rst_fail", fail, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_idx", sample_idx, 0);
    check("t6_rst_mismatch", mismatch_cnt, 0);
    check("t6_rst_ff_idx", first_fail_idx, 0);
    check("t6_rst_ff_exp", first_fail_exp, 0);
    check("t6_rst_stim", stim_stb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6b) zero settle window: strobe on the cycle after start
    ch_mask = 4'b0000;
    check("t6z_idle_stim", stim_stb_z, 0);
    start_z = 1'b1;
    @(negedge clk);
    start_z = 1'b0;
    cyc = 1;
    check("t6z_first_stim", stim_stb_z, 1);
    while (!done_z && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6z_done_cyc", cyc, 6);
    check("t6z_pass", pass_z, 1);
    check("t6z_sample_idx", sample_idx_z, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
